// File: rtl/bk_adder_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder/subtractor.
// Prefix operator, tree depth and the generate/propagate pair type live here.
package bk_adder_pkg;

   localparam int MAX_WIDTH = 64;

   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   // (G,P) o (G',P'): hi is the more significant group, lo the less significant.
   function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
      pg_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

   function automatic int bk_levels(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bk_adder_pipe_if.sv
// Operand/result handshake bundle for bk_adder_pipe.
// The ovf signal exists only when BK_OVF_EN is defined.
interface bk_adder_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c_out;
`ifdef BK_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
`ifdef BK_OVF_EN
      input  in_ready, out_valid, s, c_out, ovf
`else
      input  in_ready, out_valid, s, c_out
`endif
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
`ifdef BK_OVF_EN
      output in_ready, out_valid, s, c_out, ovf
`else
      output in_ready, out_valid, s, c_out
`endif
   );

endinterface

// File: rtl/bk_adder_pipe_prefix_tree.sv
// Combinational Brent-Kung prefix tree over positions 0..WIDTH (position 0 = carry-in).
// Produces the group generate G_i:0 for every position.
module bk_prefix_tree
   import bk_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  pg_t  [WIDTH:0] pg_i,
   output logic [WIDTH:0] gg_o
);
   localparam int LEVELS = bk_levels(WIDTH);

   pg_t [WIDTH:0] node;

   // In-place sweeps are safe: within a level no node reads a slot written at that level.
   always_comb begin
      node = pg_i;
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = (1 << (l + 1)) - 1; i <= WIDTH; i += (1 << (l + 1))) begin
            node[i] = pg_combine(node[i], node[i - (1 << l)]);
         end
      end
      for (int l = LEVELS - 2; l >= 0; l--) begin
         for (int i = 3 * (1 << l) - 1; i <= WIDTH; i += (1 << (l + 1))) begin
            node[i] = pg_combine(node[i], node[i - (1 << l)]);
         end
      end
   end

   for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_out
      assign gg_o[gi] = node[gi].g;
   end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined WIDTH-bit Brent-Kung adder/subtractor with valid/ready flow control.
// Stage 1 = P/G, stage 2 = prefix tree, stage 3 = sum (optionally registered). BK_OVF_EN adds ovf.
module bk_adder_pipe
   import bk_adder_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter bit PIPE_OUT_REG = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   bk_adder_pipe_if.slave bus
);
   logic [WIDTH-1:0] beff;
   logic             cin;
   pg_t  [WIDTH:0]   pg1_d;
   pg_t  [WIDTH:0]   pg1_q;
   logic             v1_q;
   logic             v2_q;
   logic [WIDTH:0]   gg2_d;
   logic [WIDTH:0]   gg2_q;
   logic [WIDTH-1:0] p2_d;
   logic [WIDTH-1:0] p2_q;
   logic [WIDTH-1:0] s3_d;
   logic             c3_d;
   logic             ld1;
   logic             ld2;
   logic             adv3;
`ifdef BK_OVF_EN
   logic             ovf3_d;
`endif

   // Subtraction is A + ~B + !borrow_in; position 0 of the tree carries that bit.
   always_comb begin
      beff     = bus.sub ? ~bus.b : bus.b;
      cin      = bus.c_in ^ bus.sub;
      pg1_d    = '0;
      pg1_d[0].g = cin;
      for (int i = 0; i < WIDTH; i++) begin
         pg1_d[i + 1].g = bus.a[i] & beff[i];
         pg1_d[i + 1].p = bus.a[i] ^ beff[i];
      end
   end

   assign ld2          = !v2_q | adv3;
   assign ld1          = !v1_q | ld2;
   assign bus.in_ready = ld1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         pg1_q <= '0;
      end else if (ld1) begin
         v1_q <= bus.in_valid;
         if (bus.in_valid) begin
            pg1_q <= pg1_d;
         end
      end
   end

   bk_prefix_tree #(
      .WIDTH (WIDTH)
   ) u_tree (
      .pg_i (pg1_q),
      .gg_o (gg2_d)
   );

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_p2
      assign p2_d[gi] = pg1_q[gi + 1].p;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q  <= 1'b0;
         gg2_q <= '0;
         p2_q  <= '0;
      end else if (ld2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            gg2_q <= gg2_d;
            p2_q  <= p2_d;
         end
      end
   end

   assign s3_d = p2_q ^ gg2_q[WIDTH-1:0];
   assign c3_d = gg2_q[WIDTH];
`ifdef BK_OVF_EN
   assign ovf3_d = gg2_q[WIDTH-1] ^ gg2_q[WIDTH];
`endif

   if (PIPE_OUT_REG) begin : g_out_reg
      logic             v3_q;
      logic [WIDTH-1:0] s3_q;
      logic             c3_q;
`ifdef BK_OVF_EN
      logic             ovf3_q;
`endif

      assign adv3 = !v3_q | bus.out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v3_q <= 1'b0;
            s3_q <= '0;
            c3_q <= 1'b0;
`ifdef BK_OVF_EN
            ovf3_q <= 1'b0;
`endif
         end else if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
               s3_q <= s3_d;
               c3_q <= c3_d;
`ifdef BK_OVF_EN
               ovf3_q <= ovf3_d;
`endif
            end
         end
      end

      assign bus.out_valid = v3_q;
      assign bus.s         = s3_q;
      assign bus.c_out     = c3_q;
`ifdef BK_OVF_EN
      assign bus.ovf       = ovf3_q;
`endif
   end else begin : g_out_comb
      // Stage 2 is the last register; the sum is formed on its outputs.
      assign adv3          = bus.out_ready;
      assign bus.out_valid = v2_q;
      assign bus.s         = s3_d;
      assign bus.c_out     = c3_d;
`ifdef BK_OVF_EN
      assign bus.ovf       = ovf3_d;
`endif
   end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed corner cases, random streaming,
// backpressure, random flow control and mid-stream reset against an arithmetic model.
module tb_bk_adder_pipe;
   localparam int W   = 16;
   localparam bit POR = 1'b1;
   localparam int LAT = POR ? 3 : 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   bk_adder_pipe_if #(.WIDTH(W)) bus();

   bk_adder_pipe #(
      .WIDTH        (W),
      .PIPE_OUT_REG (POR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } res_t;

   res_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Plain integer arithmetic: unsigned result for S/C_OUT, signed result for overflow.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic sub);
      longint ua, ub, sa, sb, r, sr, lim;
      res_t   m;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lim = longint'(1) << (W - 1);
      if (sub) begin
         r   = ua - ub - longint'(c);
         sr  = sa - sb - longint'(c);
         m.c = (r >= 0);
      end else begin
         r   = ua + ub + longint'(c);
         sr  = sa + sb + longint'(c);
         m.c = (r >= (longint'(1) << W));
      end
      m.s = r[W-1:0];
      m.o = (sr >= lim) || (sr < -lim);
      return m;
   endfunction

   // Result checker: every valid output is compared with the oldest outstanding beat.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
               check_eq("s", 64'(bus.s), 64'(exp_q[0].s));
               check_eq("c_out", 64'(bus.c_out), 64'(exp_q[0].c));
`ifdef BK_OVF_EN
               check_eq("ovf", 64'(bus.ovf), 64'(exp_q[0].o));
`endif
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
      end
   end

   task automatic drive(input bit vld, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic sub, input bit ordy, output bit acc);
      @(posedge clk);
      #1;
      bus.in_valid  = vld;
      bus.a         = a;
      bus.b         = b;
      bus.c_in      = c;
      bus.sub       = sub;
      bus.out_ready = ordy;
      @(negedge clk);
      acc = vld && bus.in_ready;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && k < 40) begin
         idle(1);
         k++;
      end
      check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic sub, input logic [W-1:0] es, input logic ec,
                           input logic eo);
      bit acc;
      drive(1'b1, a, b, c, sub, 1'b1, acc);
      check_eq("dir_accept", 64'(acc), 64'd1);
      idle(LAT - 1);
      check_eq("dir_early", 64'(bus.out_valid), 64'd0);
      idle(1);
      check_eq("dir_valid", 64'(bus.out_valid), 64'd1);
      check_eq("dir_s", 64'(bus.s), 64'(es));
      check_eq("dir_cout", 64'(bus.c_out), 64'(ec));
`ifdef BK_OVF_EN
      check_eq("dir_ovf", 64'(bus.ovf), 64'(eo));
`else
      if (eo === 1'bx) $display("note: unexpected X overflow expectation");
`endif
      idle(1);
      check_eq("dir_gone", 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      bit           acc;
      int           cnt, guard;
      logic [W-1:0] ca, cb;
      logic         cc, cs;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.a         = '1;
      bus.b         = 16'h0001;
      bus.c_in      = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_ovalid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_s", 64'(bus.s), 64'd0);
      check_eq("rst_cout", 64'(bus.c_out), 64'd0);
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("rst_irdy", 64'(bus.in_ready), 64'd1);

      send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      send_dir(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send_dir(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      send_dir(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      send_dir(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

      for (int k = 0; k < 64; k++) begin
         drive(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, acc);
         check_eq("stream_irdy", 64'(acc), 64'd1);
         if (k >= LAT) check_eq("stream_ovalid", 64'(bus.out_valid), 64'd1);
      end
      drain();

      // Backpressure: the pipe must take exactly one beat per stage, then stall.
      ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom); cs = 1'($urandom);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, ca, cb, cc, cs, 1'b0, acc);
         if (acc) begin
            cnt++;
            ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom); cs = 1'($urandom);
         end
      end
      check_eq("bp_accepted", 64'(cnt), 64'(LAT));
      check_eq("bp_irdy", 64'(bus.in_ready), 64'd0);
      cnt = 0;
      guard = 0;
      while (cnt < 8 && guard < 40) begin
         drive(1'b1, ca, cb, cc, cs, 1'b1, acc);
         if (acc) begin
            cnt++;
            ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom); cs = 1'($urandom);
         end
         guard++;
      end
      check_eq("bp_release", 64'(cnt), 64'd8);
      drain();

      // Random valid/ready mix; the producer holds a beat until it is taken.
      for (int k = 0; k < 200; k++) begin
         drive(1'($urandom_range(0, 3) != 0), ca, cb, cc, cs,
               1'($urandom_range(0, 3) != 0), acc);
         if (acc) begin
            ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom); cs = 1'($urandom);
         end
      end
      drain();

      // Reset with beats in flight: output must drop at once, nothing resurfaces.
      for (int k = 0; k < 3; k++)
         drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1, acc);
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check_eq("mid_rst_ovalid", 64'(bus.out_valid), 64'd0);
      check_eq("mid_rst_s", 64'(bus.s), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(8);
      check_eq("post_rst_ovalid", 64'(bus.out_valid), 64'd0);
      send_dir(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h2469, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
